// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command responder: FSM states,
// frame sync bytes, command codes and response status codes.
package uart_cmd_pkg;

    typedef enum logic [3:0] {
        IDLE,
        GET_CMD,
        GET_ADDR,
        GET_DATA,
        GET_CHK,
        EXEC,
        RD_WAIT,
        SEND_SYNC,
        SEND_STAT,
        SEND_DATA,
        SEND_CHK
    } state_t;

    localparam logic [7:0] SYNC_REQ     = 8'hA5;
    localparam logic [7:0] SYNC_RSP     = 8'h5A;

    localparam logic [7:0] CMD_WRITE    = 8'h01;
    localparam logic [7:0] CMD_READ     = 8'h02;

    localparam logic [7:0] STAT_OK      = 8'h00;
    localparam logic [7:0] STAT_BAD_CHK = 8'h01;
    localparam logic [7:0] STAT_BAD_CMD = 8'h02;

    // Error counter step that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_cmd_responder.sv
// UART command responder: parses A5/CMD/ADDR/DATA/CHK request frames from a
// show-ahead RX FIFO, performs one register write or read on an external
// register file, and answers with a 5A/STATUS/RDATA/CHK frame into a TX FIFO.
//
// Optional feature: define UART_CMD_TIMEOUT_EN to abandon a partial request
// after TIMEOUT_CYCLES idle cycles (counted as a protocol error, no response).
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic       o_rx_rd_en,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_full,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_wr_en,
    output logic       o_reg_rd_en,
    input  logic [7:0] i_reg_rdata,
    output logic       o_busy,
    output logic [7:0] o_err_count
);

    // A zero timeout would make every GET_* cycle expire at once.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t     state;
    logic [7:0] cmd_q;
    logic [7:0] addr_q;
    logic [7:0] data_q;
    logic [7:0] status_q;
    logic [7:0] rdata_q;

    logic       rx_state;
    logic       tx_state;
    logic       pop;
    logic       to_hit;
    logic [7:0] calc_chk;
    logic       bad_chk;
    logic       bad_cmd;
    logic [7:0] tx_byte;

    assign rx_state = (state == IDLE)     || (state == GET_CMD) ||
                      (state == GET_ADDR) || (state == GET_DATA) ||
                      (state == GET_CHK);
    assign tx_state = (state == SEND_SYNC) || (state == SEND_STAT) ||
                      (state == SEND_DATA) || (state == SEND_CHK);

    // FIFO handshakes depend on same-cycle FIFO flags, so they are decoded
    // from the registered state; reset blocks any pop or push in that cycle.
    assign pop        = rx_state && i_rx_valid && !rst;
    assign o_rx_rd_en = pop;
    assign o_tx_valid = tx_state && !i_tx_full && !rst;
    assign o_tx_data  = rst ? 8'h00 : tx_byte;
    assign o_busy     = (state != IDLE);

    // Frame judgement uses the CHK byte as it is popped.
    assign calc_chk = cmd_q ^ addr_q ^ data_q;
    assign bad_chk  = (calc_chk != i_rx_data);
    assign bad_cmd  = (cmd_q != CMD_WRITE) && (cmd_q != CMD_READ);

    // Response byte for the current SEND_* state.
    always_comb begin
        tx_byte = 8'h00;
        case (state)
            SEND_SYNC: tx_byte = SYNC_RSP;
            SEND_STAT: tx_byte = status_q;
            SEND_DATA: tx_byte = rdata_q;
            SEND_CHK:  tx_byte = status_q ^ rdata_q;
            default:   tx_byte = 8'h00;
        endcase
    end

`ifdef UART_CMD_TIMEOUT_EN
    logic        in_get;
    logic [31:0] to_cnt;

    assign in_get = (state == GET_CMD)  || (state == GET_ADDR) ||
                    (state == GET_DATA) || (state == GET_CHK);
    assign to_hit = in_get && !i_rx_valid &&
                    (to_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Count consecutive starved cycles inside a frame; any pop restarts it.
    always_ff @(posedge clk) begin
        if (rst || !in_get || pop || to_hit)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 32'd1;
    end
`else
    assign to_hit = 1'b0;
`endif

    // Main request/response FSM with registered register-port strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            status_q    <= '0;
            rdata_q     <= '0;
            o_reg_addr  <= '0;
            o_reg_wdata <= '0;
            o_reg_wr_en <= 1'b0;
            o_reg_rd_en <= 1'b0;
            o_err_count <= '0;
        end else begin
            o_reg_wr_en <= 1'b0;
            o_reg_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    // Non-sync bytes are silently dropped while hunting.
                    if (pop && i_rx_data == SYNC_REQ)
                        state <= GET_CMD;
                end
                GET_CMD: begin
                    if (pop) begin
                        cmd_q <= i_rx_data;
                        state <= GET_ADDR;
                    end else if (to_hit) begin
                        state       <= IDLE;
                        o_err_count <= sat_inc(o_err_count);
                    end
                end
                GET_ADDR: begin
                    if (pop) begin
                        addr_q <= i_rx_data;
                        state  <= GET_DATA;
                    end else if (to_hit) begin
                        state       <= IDLE;
                        o_err_count <= sat_inc(o_err_count);
                    end
                end
                GET_DATA: begin
                    if (pop) begin
                        data_q <= i_rx_data;
                        state  <= GET_CHK;
                    end else if (to_hit) begin
                        state       <= IDLE;
                        o_err_count <= sat_inc(o_err_count);
                    end
                end
                GET_CHK: begin
                    // Decide here so the register strobe is a flop that is
                    // high for exactly the EXEC cycle. Checksum error wins.
                    if (pop) begin
                        state <= EXEC;
                        if (bad_chk) begin
                            status_q <= STAT_BAD_CHK;
                            rdata_q  <= 8'h00;
                        end else if (bad_cmd) begin
                            status_q <= STAT_BAD_CMD;
                            rdata_q  <= 8'h00;
                        end else if (cmd_q == CMD_WRITE) begin
                            status_q    <= STAT_OK;
                            rdata_q     <= data_q;
                            o_reg_wr_en <= 1'b1;
                            o_reg_addr  <= addr_q;
                            o_reg_wdata <= data_q;
                        end else begin
                            status_q    <= STAT_OK;
                            rdata_q     <= 8'h00;
                            o_reg_rd_en <= 1'b1;
                            o_reg_addr  <= addr_q;
                        end
                    end else if (to_hit) begin
                        state       <= IDLE;
                        o_err_count <= sat_inc(o_err_count);
                    end
                end
                EXEC: begin
                    if (status_q != STAT_OK)
                        o_err_count <= sat_inc(o_err_count);
                    state <= o_reg_rd_en ? RD_WAIT : SEND_SYNC;
                end
                RD_WAIT: begin
                    rdata_q <= i_reg_rdata;
                    state   <= SEND_SYNC;
                end
                SEND_SYNC: if (!i_tx_full) state <= SEND_STAT;
                SEND_STAT: if (!i_tx_full) state <= SEND_DATA;
                SEND_DATA: if (!i_tx_full) state <= SEND_CHK;
                SEND_CHK:  if (!i_tx_full) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: models the RX/TX FIFOs and the
// external register file, and checks responses against hand-computed frames.
module tb_uart_cmd_responder;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_valid = 1'b0;
    logic       o_rx_rd_en;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_full = 1'b0;
    logic [7:0] o_reg_addr;
    logic [7:0] o_reg_wdata;
    logic       o_reg_wr_en;
    logic       o_reg_rd_en;
    logic [7:0] i_reg_rdata = 8'h00;
    logic       o_busy;
    logic [7:0] o_err_count;

    int checks = 0;
    int failures = 0;

    // RX FIFO model: tasks own wr_ptr, the pop process owns rd_ptr.
    logic [7:0] rx_buf [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    int         pop_cyc [0:255];

    // TX FIFO capture.
    logic [7:0] tx_buf [0:1023];
    int         tx_cyc [0:1023];
    int         tx_cnt = 0;
    logic       tx_when_full = 1'b0;

    // Register-file model.
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] rd_val = 8'h00;
    logic       both_seen = 1'b0;

    int cyc = 0;

    uart_cmd_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_rx_rd_en  (o_rx_rd_en),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_full   (i_tx_full),
        .o_reg_addr  (o_reg_addr),
        .o_reg_wdata (o_reg_wdata),
        .o_reg_wr_en (o_reg_wr_en),
        .o_reg_rd_en (o_reg_rd_en),
        .i_reg_rdata (i_reg_rdata),
        .o_busy      (o_busy),
        .o_err_count (o_err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (o_rx_rd_en) begin
            rd_ptr          <= rd_ptr + 8'd1;
            pop_cyc[rd_ptr] <= cyc;
        end
    end

    always @(negedge clk) begin
        i_rx_valid = (wr_ptr != rd_ptr);
        i_rx_data  = (wr_ptr != rd_ptr) ? rx_buf[rd_ptr] : 8'h00;
    end

    always @(posedge clk) begin
        if (o_tx_valid) begin
            if (i_tx_full) tx_when_full <= 1'b1;
            tx_buf[tx_cnt % 1024] <= o_tx_data;
            tx_cyc[tx_cnt % 1024] <= cyc;
            tx_cnt <= tx_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (o_reg_wr_en) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= o_reg_addr;
            wr_data <= o_reg_wdata;
        end
        if (o_reg_rd_en) begin
            rd_cnt  <= rd_cnt + 1;
            rd_addr <= o_reg_addr;
        end
        if (o_reg_wr_en && o_reg_rd_en) both_seen <= 1'b1;
        i_reg_rdata <= o_reg_rd_en ? rd_val : 8'h00;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_buf[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic push_frame(input logic [7:0] c, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] k);
        push(8'hA5); push(c); push(a); push(d); push(k);
    endtask

    // Bounded wait for n response bytes past base.
    task automatic wait_tx(input int base, input int n);
        int k;
        k = 0;
        while ((tx_cnt - base) < n && k < 400) begin
            step(1);
            k++;
        end
    endtask

    function automatic logic [31:0] rsp(input int base);
        return {tx_buf[base % 1024], tx_buf[(base + 1) % 1024],
                tx_buf[(base + 2) % 1024], tx_buf[(base + 3) % 1024]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        checks++;
        if ({o_rx_rd_en, o_tx_valid, o_reg_wr_en, o_reg_rd_en, o_busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b want 00000",
                     {o_rx_rd_en, o_tx_valid, o_reg_wr_en, o_reg_rd_en, o_busy});
        end
        checks++;
        if (o_tx_data !== 8'h00) begin
            failures++; $display("FAIL reset_tx_data: got %h want 00", o_tx_data);
        end
        checks++;
        if (o_reg_addr !== 8'h00 || o_reg_wdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_reg_bus: got %h/%h want 00/00", o_reg_addr, o_reg_wdata);
        end
        checks++;
        if (o_err_count !== 8'h00) begin
            failures++; $display("FAIL reset_err_count: got %h want 00", o_err_count);
        end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_write();
        int base, w0, r0;
        base = tx_cnt; w0 = wr_cnt; r0 = rd_cnt;
        push_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
        wait_tx(base, 4);
        step(2);
        checks++;
        if (tx_cnt - base != 4 || rsp(base) !== 32'h5A003C3C) begin
            failures++;
            $display("FAIL write_rsp: got %0d bytes %h want 4 bytes 5a003c3c",
                     tx_cnt - base, rsp(base));
        end
        checks++;
        if (wr_cnt - w0 != 1 || rd_cnt - r0 != 0) begin
            failures++;
            $display("FAIL write_strobes: got wr=%0d rd=%0d want wr=1 rd=0",
                     wr_cnt - w0, rd_cnt - r0);
        end
        checks++;
        if (wr_addr !== 8'h10 || wr_data !== 8'h3C) begin
            failures++;
            $display("FAIL write_bus: got addr=%h data=%h want 10/3c", wr_addr, wr_data);
        end
        checks++;
        if (o_busy !== 1'b0 || o_err_count !== 8'h00) begin
            failures++;
            $display("FAIL write_idle: got busy=%b err=%h want 0/00", o_busy, o_err_count);
        end
    endtask

    task automatic test_read();
        int base, w0, r0;
        base = tx_cnt; w0 = wr_cnt; r0 = rd_cnt;
        rd_val = 8'h77;
        push_frame(8'h02, 8'h20, 8'h00, 8'h22);
        wait_tx(base, 4);
        step(2);
        checks++;
        if (tx_cnt - base != 4 || rsp(base) !== 32'h5A007777) begin
            failures++;
            $display("FAIL read_rsp: got %0d bytes %h want 4 bytes 5a007777",
                     tx_cnt - base, rsp(base));
        end
        checks++;
        if (rd_cnt - r0 != 1 || wr_cnt - w0 != 0 || rd_addr !== 8'h20) begin
            failures++;
            $display("FAIL read_strobes: got rd=%0d wr=%0d addr=%h want 1/0/20",
                     rd_cnt - r0, wr_cnt - w0, rd_addr);
        end
    endtask

    task automatic test_bad_chk();
        int base, w0, r0;
        base = tx_cnt; w0 = wr_cnt; r0 = rd_cnt;
        push(8'h00); push(8'hFF);
        push_frame(8'h01, 8'h10, 8'h3C, 8'h00);
        wait_tx(base, 4);
        step(2);
        checks++;
        if (tx_cnt - base != 4 || rsp(base) !== 32'h5A010001) begin
            failures++;
            $display("FAIL badchk_rsp: got %0d bytes %h want 4 bytes 5a010001",
                     tx_cnt - base, rsp(base));
        end
        checks++;
        if (o_err_count !== 8'h01) begin
            failures++; $display("FAIL badchk_err: got %h want 01", o_err_count);
        end
        checks++;
        if (wr_cnt != w0 || rd_cnt != r0 || rd_ptr !== wr_ptr) begin
            failures++;
            $display("FAIL badchk_access: got wr=%0d rd=%0d rx_left=%0d want 0/0/0",
                     wr_cnt - w0, rd_cnt - r0, wr_ptr - rd_ptr);
        end
    endtask

    task automatic test_bad_cmd_stall();
        int base, w0, r0, held;
        logic vld_seen;
        base = tx_cnt; w0 = wr_cnt; r0 = rd_cnt;
        vld_seen = 1'b0;
        push_frame(8'h07, 8'h10, 8'h00, 8'h17);
        wait_tx(base, 2);
        i_tx_full = 1'b1;
        held = tx_cnt;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (o_tx_valid !== 1'b0) vld_seen = 1'b1;
        end
        checks++;
        if (tx_cnt - base != 2 || held != tx_cnt || vld_seen || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold: got bytes=%0d vld=%b busy=%b want 2/0/1",
                     tx_cnt - base, vld_seen, o_busy);
        end
        i_tx_full = 1'b0;
        wait_tx(base, 4);
        step(2);
        checks++;
        if (tx_cnt - base != 4 || rsp(base) !== 32'h5A020002) begin
            failures++;
            $display("FAIL badcmd_rsp: got %0d bytes %h want 4 bytes 5a020002",
                     tx_cnt - base, rsp(base));
        end
        checks++;
        if (o_err_count !== 8'h02 || wr_cnt != w0 || rd_cnt != r0 || tx_when_full) begin
            failures++;
            $display("FAIL badcmd_side: got err=%h wr=%0d rd=%0d txfull=%b want 02/0/0/0",
                     o_err_count, wr_cnt - w0, rd_cnt - r0, tx_when_full);
        end
    endtask

    task automatic test_back_to_back();
        int base, w0, lat1, lat2, gap;
        logic [7:0] s0, s1;
        base = tx_cnt; w0 = wr_cnt;
        s0 = wr_ptr;
        s1 = wr_ptr + 8'd5;
        push_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
        push_frame(8'h01, 8'h11, 8'h22, 8'h32);
        wait_tx(base, 8);
        step(2);
        checks++;
        if (tx_cnt - base != 8 || rsp(base) !== 32'h5A003C3C || rsp(base + 4) !== 32'h5A002222) begin
            failures++;
            $display("FAIL b2b_rsp: got %0d bytes %h %h want 8 bytes 5a003c3c 5a002222",
                     tx_cnt - base, rsp(base), rsp(base + 4));
        end
        lat1 = tx_cyc[(base + 3) % 1024] - pop_cyc[s0];
        lat2 = tx_cyc[(base + 7) % 1024] - pop_cyc[s1];
        gap  = pop_cyc[s1] - tx_cyc[(base + 3) % 1024];
        checks++;
        if (lat1 != 9 || lat2 != 9 || gap != 1) begin
            failures++;
            $display("FAIL b2b_timing: got lat=%0d,%0d gap=%0d want 9,9 gap 1", lat1, lat2, gap);
        end
        checks++;
        if (wr_cnt - w0 != 2 || wr_addr !== 8'h11 || wr_data !== 8'h22) begin
            failures++;
            $display("FAIL b2b_writes: got n=%0d addr=%h data=%h want 2/11/22",
                     wr_cnt - w0, wr_addr, wr_data);
        end
    endtask

    task automatic test_timeout();
        int base;
        logic [7:0] e0;
        base = tx_cnt; e0 = o_err_count;
        push(8'hA5); push(8'h01);
        step(TO + 20);
`ifdef UART_CMD_TIMEOUT_EN
        checks++;
        if (o_busy !== 1'b0 || o_err_count !== e0 + 8'd1 || tx_cnt != base) begin
            failures++;
            $display("FAIL timeout_abort: got busy=%b err=%h tx=%0d want 0/%h/0",
                     o_busy, o_err_count, tx_cnt - base, e0 + 8'd1);
        end
        push_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
`else
        checks++;
        if (o_busy !== 1'b1 || o_err_count !== e0 || tx_cnt != base) begin
            failures++;
            $display("FAIL timeout_wait: got busy=%b err=%h tx=%0d want 1/%h/0",
                     o_busy, o_err_count, tx_cnt - base, e0);
        end
        push(8'h10); push(8'h3C); push(8'h2D);
`endif
        wait_tx(base, 4);
        step(2);
        checks++;
        if (tx_cnt - base != 4 || rsp(base) !== 32'h5A003C3C) begin
            failures++;
            $display("FAIL timeout_after: got %0d bytes %h want 4 bytes 5a003c3c",
                     tx_cnt - base, rsp(base));
        end
    endtask

    task automatic test_reset_mid();
        int base;
        base = tx_cnt;
        rd_val = 8'h55;
        push_frame(8'h02, 8'h20, 8'h00, 8'h22);
        wait_tx(base, 1);
        rst = 1'b1;
        #1;
        checks++;
        if (o_tx_valid !== 1'b0) begin
            failures++; $display("FAIL rstmid_gate: got tx_valid=%b want 0", o_tx_valid);
        end
        step(1);
        checks++;
        if ({o_tx_valid, o_busy, o_reg_wr_en, o_reg_rd_en} !== 4'b0 || o_tx_data !== 8'h00 ||
            o_reg_addr !== 8'h00 || o_reg_wdata !== 8'h00 || o_err_count !== 8'h00) begin
            failures++;
            $display("FAIL rstmid_outs: got vld=%b busy=%b txd=%h addr=%h wd=%h err=%h want all 0",
                     o_tx_valid, o_busy, o_tx_data, o_reg_addr, o_reg_wdata, o_err_count);
        end
        checks++;
        if (tx_cnt - base != 1) begin
            failures++; $display("FAIL rstmid_bytes: got %0d want 1", tx_cnt - base);
        end
        step(1);
        rst = 1'b0;
        step(1);
        base = tx_cnt;
        rd_val = 8'h66;
        push_frame(8'h02, 8'h20, 8'h00, 8'h22);
        wait_tx(base, 4);
        step(2);
        checks++;
        if (tx_cnt - base != 4 || rsp(base) !== 32'h5A006666 || o_err_count !== 8'h00) begin
            failures++;
            $display("FAIL rstmid_next: got %0d bytes %h err=%h want 4 bytes 5a006666 err 00",
                     tx_cnt - base, rsp(base), o_err_count);
        end
    endtask

    task automatic test_saturation();
        int base;
        base = tx_cnt;
        for (int i = 0; i < 256; i++) begin
            base = tx_cnt;
            push_frame(8'h01, 8'h10, 8'h3C, 8'h00);
            wait_tx(base, 4);
        end
        step(2);
        checks++;
        if (o_err_count !== 8'hFF) begin
            failures++; $display("FAIL err_saturate: got %h want ff", o_err_count);
        end
        checks++;
        if (tx_cnt - base != 4 || rsp(base) !== 32'h5A010001) begin
            failures++;
            $display("FAIL saturate_rsp: got %0d bytes %h want 4 bytes 5a010001",
                     tx_cnt - base, rsp(base));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_chk();
        test_bad_cmd_stall();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_saturation();
        checks++;
        if (both_seen !== 1'b0) begin
            failures++; $display("FAIL wr_rd_overlap: got 1 want 0");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, inter-byte timeout in clk cycles (used only with the timeout macro).
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk  input  1  system clock; rst  input  1  reset.
REQ-003 i_rx_data  input  8  head byte of RX FIFO, show-ahead, valid while i_rx_valid=1.
REQ-004 i_rx_valid  input  1  RX FIFO not empty.
REQ-005 o_rx_rd_en  output  1  single-cycle pop of RX FIFO head.
REQ-006 o_tx_data  output  8  byte to TX FIFO; o_tx_valid  output  1  TX FIFO write strobe; i_tx_full  input  1  TX FIFO full.
REQ-007 o_reg_addr  output  8; o_reg_wdata  output  8; o_reg_wr_en  output  1; o_reg_rd_en  output  1; i_reg_rdata  input  8, valid exactly one cycle after o_reg_rd_en.
REQ-008 o_busy  output  1  high in any state other than IDLE; o_err_count  output  8  saturating protocol-error count.

Function
REQ-009 Request frame SHALL be SYNC_REQ(0xA5), CMD, ADDR, DATA, CHK; CHK = CMD^ADDR^DATA.
REQ-010 Response frame SHALL be SYNC_RSP(0x5A), STATUS, RDATA, CHK; CHK = STATUS^RDATA.
REQ-011 FSM states SHALL be IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, RD_WAIT, SEND_SYNC, SEND_STAT, SEND_DATA, SEND_CHK.
REQ-012 Byte consumption: in IDLE/GET_* with i_rx_valid=1, o_rx_rd_en SHALL pulse one cycle and the byte is latched that cycle; at most one pop per cycle.
REQ-013 IDLE SHALL discard any byte other than 0xA5 without error count; 0xA5 -> GET_CMD.
REQ-014 GET_CHK -> EXEC; EXEC evaluates in one cycle: checksum mismatch -> STATUS 0x01, no register access; CMD not 0x01/0x02 -> STATUS 0x02, no access; both errors -> STATUS 0x01.
REQ-015 CMD 0x01 (write), good frame: o_reg_wr_en pulses one cycle in EXEC with o_reg_addr=ADDR, o_reg_wdata=DATA; STATUS 0x00; RDATA=DATA echo; -> SEND_SYNC.
REQ-016 CMD 0x02 (read), good frame: o_reg_rd_en pulses in EXEC with o_reg_addr=ADDR; RD_WAIT captures i_reg_rdata as RDATA; STATUS 0x00; -> SEND_SYNC.
REQ-017 Error frames SHALL send a response with RDATA=0x00 and increment o_err_count (saturate at 0xFF).
REQ-018 Each SEND_* state SHALL assert o_tx_valid for exactly one cycle with its byte, only when i_tx_full=0, then advance; while i_tx_full=1 it holds with o_tx_valid=0.
REQ-019 SEND_CHK -> IDLE; back-to-back frames: minimum 9 cycles from SYNC pop to final response byte with FIFOs never empty/full.
REQ-020 RX bytes SHALL NOT be popped during EXEC, RD_WAIT or SEND_*.
REQ-021 o_reg_wr_en and o_reg_rd_en SHALL never be high together; o_reg_addr/o_reg_wdata hold last values outside strobes.

Reset
REQ-022 rst=1 at a clk edge SHALL force IDLE and zero o_rx_rd_en, o_tx_valid, o_tx_data, o_reg_*, o_busy, o_err_count, latched fields and timeout counter, including mid-frame or mid-response; partial frames are abandoned.

Configuration
REQ-023 Macro UART_CMD_TIMEOUT_EN defined: in GET_* states, TIMEOUT_CYCLES consecutive cycles with i_rx_valid=0 SHALL return FSM to IDLE, increment o_err_count, send no response; counter clears on every pop.
REQ-024 Macro undefined: no timeout counter is built; GET_* states wait indefinitely; TIMEOUT_CYCLES is ignored.

Structure
REQ-025 Package uart_cmd_pkg SHALL hold the state enum, SYNC_REQ/SYNC_RSP constants, CMD codes (WRITE 0x01, READ 0x02) and STATUS codes (OK 0x00, BAD_CHK 0x01, BAD_CMD 0x02).
REQ-026 Single module, no sub-module; the register file is external to this block.

Verification
REQ-027 RX A5 01 10 3C 2D, tx not full -> o_reg_wr_en once, addr 0x10, wdata 0x3C; TX 5A 00 3C 3C.
REQ-028 RX A5 02 20 00 22, i_reg_rdata=0x77 -> o_reg_rd_en once, addr 0x20; TX 5A 00 77 77.
REQ-029 RX 00 FF A5 01 10 3C 00 -> two leading bytes dropped, no reg access; TX 5A 01 00 01; o_err_count=1.
REQ-030 RX A5 07 10 00 17 -> TX 5A 02 00 02, no reg access; i_tx_full held 1 for 20 cycles mid-response -> bytes stall, none lost or duplicated.
REQ-031 RX A5 01 then idle TIMEOUT_CYCLES (macro on) -> IDLE, o_err_count +1, no TX; macro off -> still GET_ADDR; rst pulse during SEND_STAT -> all outputs 0, next frame answered normally.
